// File: rtl/ws2812_pkg.sv
// Shared types and defaults for the WS2812/SK6812 chain driver.
package ws2812_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHigh,
        StLow,
        StLatch
    } state_t;

    // Default bit timing in clock cycles at 10 MHz
    localparam int unsigned DefT0H = 4;
    localparam int unsigned DefT0L = 8;
    localparam int unsigned DefT1H = 7;
    localparam int unsigned DefT1L = 6;
    localparam int unsigned DefRes = 500;

    // Colour words in wire order: G, R, B (and W for GRBW parts)
    localparam logic [23:0] GrbRed     = 24'h00FF00;
    localparam logic [23:0] GrbGreen   = 24'hFF0000;
    localparam logic [23:0] GrbBlue    = 24'h0000FF;
    localparam logic [23:0] GrbWhite   = 24'hFFFFFF;
    localparam logic [23:0] GrbOff     = 24'h000000;
    localparam logic [31:0] GrbwWhite  = 32'h000000FF;
    localparam logic [31:0] GrbwOff    = 32'h00000000;

    function automatic int unsigned phase_cnt_width(input int unsigned t0h, input int unsigned t1h,
                                                    input int unsigned t0l, input int unsigned t1l,
                                                    input int unsigned res);
        int unsigned m;
        m = t0h;
        if (t1h > m)     m = t1h;
        if (t0l + 1 > m) m = t0l + 1;
        if (t1l + 1 > m) m = t1l + 1;
        if (res > m)     m = res;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Phase timer: counts the length of the current high, low or latch phase and flags its last cycle.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H = DefT0H,
    parameter int unsigned T0L = DefT0L,
    parameter int unsigned T1H = DefT1H,
    parameter int unsigned T1L = DefT1L,
    parameter int unsigned RES = DefRes,
    parameter int unsigned CW  = 9
) (
    input  logic   clk,
    input  logic   rst,
    input  state_t phase,
    input  logic   bit_val,
    output logic   phase_done
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len;
    logic          counting;

    always_comb begin
        len = '0;
        case (phase)
            StHigh:  len = bit_val ? CW'(T1H) : CW'(T0H);
            StLow:   len = bit_val ? CW'(T1L) : CW'(T0L);
            StLatch: len = CW'(RES);
            default: len = '0;
        endcase
        counting   = phase inside {StHigh, StLow, StLatch};
        phase_done = counting && (cnt_q == len - 1'b1);
        // Restart from zero on every phase boundary so each phase starts a fresh count
        cnt_d      = (phase_done || !counting) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ws2812_chain_driver.sv
// WS2812/SK6812 chain driver: pixel RAM, frame sequencing FSM and registered serial output.
module ws2812_chain_driver
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned BITS_PER_LED = 24,
    parameter int unsigned T0H          = DefT0H,
    parameter int unsigned T0L          = DefT0L,
    parameter int unsigned T1H          = DefT1H,
    parameter int unsigned T1L          = DefT1L,
    parameter int unsigned RES          = DefRes,
    localparam int unsigned AW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [BITS_PER_LED-1:0] wr_data,
    input  logic                    start,
    input  logic                    repeat_en,
    output logic                    busy,
    output logic                    done,
    output logic                    ws_out
);

    localparam int unsigned CW = phase_cnt_width(T0H, T1H, T0L, T1L, RES);
    localparam int unsigned BW = $clog2(BITS_PER_LED);

    if (!(BITS_PER_LED == 24 || BITS_PER_LED == 32)) begin : gen_bad_width
        $error("BITS_PER_LED must be 24 or 32");
    end

    logic [BITS_PER_LED-1:0] mem [NUM_LEDS];

    state_t                  state_q, state_d;
    logic [AW-1:0]           pix_q, pix_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [BITS_PER_LED-1:0] shift_q, shift_d;
    logic                    ws_out_q;
    logic                    phase_done;

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < (AW+1)'(NUM_LEDS))) begin
            mem[wr_addr] <= wr_data;
        end
    end

    ws2812_bit_encoder #(
        .T0H (T0H),
        .T0L (T0L),
        .T1H (T1H),
        .T1L (T1L),
        .RES (RES),
        .CW  (CW)
    ) u_bit_encoder (
        .clk        (clk),
        .rst        (rst),
        .phase      (state_q),
        .bit_val    (shift_q[BITS_PER_LED-1]),
        .phase_done (phase_done)
    );

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle: begin
                pix_d = '0;
                if (start) state_d = StLoad;
            end
            StLoad: begin
                // Read happens here, so a write to this pixel from now on lands in the next frame
                shift_d = mem[pix_q];
                bit_d   = BW'(BITS_PER_LED - 1);
                state_d = StHigh;
            end
            StHigh: begin
                if (phase_done) state_d = StLow;
            end
            StLow: begin
                if (phase_done) begin
                    if (bit_q == '0) begin
                        if (pix_q == AW'(NUM_LEDS - 1)) begin
                            state_d = StLatch;
                        end else begin
                            pix_d   = pix_q + 1'b1;
                            state_d = StLoad;
                        end
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        shift_d = {shift_q[BITS_PER_LED-2:0], 1'b0};
                        state_d = StHigh;
                    end
                end
            end
            StLatch: begin
                if (phase_done) begin
                    pix_d   = '0;
                    state_d = repeat_en ? StLoad : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pix_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            ws_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            ws_out_q <= (state_d == StHigh);
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StLatch) && phase_done;
    assign ws_out = ws_out_q;

endmodule
